cas_sort_ctrl: RTL
==================

Name: cas_sort_ctrl

Overview:
- Sequential sorter controller that time-shares one two-input compare-and-swap unit (`cas`, one combinational instance) across an N-entry register bank.
- Loads N unsigned SNG-width words serially, then runs an odd-even transposition sort one compare per cycle, then drains the words in descending order.
- Sits ahead of the DSC multiplier/SNG pipeline, where ranked operands are consumed.

Parameters:
- SNG_WIDTH, 10, bit width of each unsigned word.
- N, 8, words per sort batch; legal range 3..64.
- IDX_W, $clog2(N), width of the index and count fields.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  in_data is valid.
- in_data  in  SNG_WIDTH  word to load.
- in_ready  out  1  high only in LOAD; gated low while rst=1.
- out_valid  out  1  high only in DRAIN; gated low while rst=1.
- out_data  out  SNG_WIDTH  current drained word, mem[rd_idx].
- out_ready  in  1  consumer accepts out_data.
- out_last  out  1  out_valid and rd_idx==N-1.
- busy  out  1  state==SORT.

Behaviour:
- Reset:
  - state=LOAD, wr_idx=rd_idx=pair_idx=0, phase=0, swap_seen=0, quiet_phases=0.
  - Register bank contents are don't-care.
  - All outputs read 0 during the reset cycle. in_ready=1 from the first cycle after rst deasserts.
- CAS semantics:
  - a_new=max(a,b), b_new=min(a,b), unsigned compare.
  - Equal operands do not swap.
  - swap = (a_new != a).
- LOAD:
  - Each cycle with in_valid&in_ready: mem[wr_idx]<=in_data, wr_idx++.
  - When the N-th word is accepted: state<=SORT next cycle, wr_idx<=0, phase=0, pair_idx=0.
  - in_valid low leaves state unchanged; idle indefinitely is legal.
- SORT, one compare per cycle:
  - Operands are a=mem[2*pair_idx+p], b=mem[2*pair_idx+p+1], where p=phase[0].
  - Both results are written back the same cycle. swap_seen|=swap.
  - Pairs per phase: even phase floor(N/2), odd phase floor((N-1)/2).
  - On the last pair of a phase:
    - quiet_phases <= (swap_seen|swap) ? 0 : quiet_phases+1.
    - swap_seen<=0, pair_idx<=0, phase++.
  - Exit to DRAIN next cycle when the completing phase makes quiet_phases reach 2, or phase N-1 completes, whichever is first.
  - Worst-case latency is the sum of pairs over N phases. For N=4 that is 6 cycles; for N=8 it is 28.
  - in_ready=0 and in_valid is ignored.
- DRAIN:
  - out_data = mem[rd_idx].
  - On out_valid&out_ready: rd_idx++.
  - After the transfer with out_last=1: state<=LOAD, rd_idx<=0.
  - out_ready low holds out_data and out_valid stable.
- Result ordering: mem[0] is largest, so the drain order is non-increasing. Duplicates are preserved.
- Reset mid-operation: any state returns to LOAD. The partial batch is discarded and no out_valid pulse follows.
- No simultaneous load/drain: a new batch is accepted only after the last word is drained.

Decomposition:
- Package cas_sort_pkg holds:
  - state enum {LOAD, SORT, DRAIN}.
  - SNG_WIDTH default constant.
  - function pairs_in_phase(N, parity).
- Sub-module: the existing combinational `cas`, instantiated once, with operand muxes and write-back in cas_sort_ctrl.
- Register bank stays inline as flops; no RAM.

Test Plan:
- N=4, load 1,5,3,9 with in_valid constant, out_ready=1 → out_data 9,5,3,1, with out_last on 1. busy high ≤6 cycles.
- N=4, load 9,7,5,1 (already sorted) → busy exactly 3 cycles (phase0 2 pairs, phase1 1 pair, both quiet), then output 9,7,5,1.
- N=4, load 1023,0,1023,0 → output 1023,1023,0,0; equal pairs cause no swap.
- N=4, load 0,1,2,3 (reverse) → all 4 phases run, busy 6 cycles, output 3,2,1,0.
- Drain backpressure: toggle out_ready 1,0,0,1 → each word held stable while stalled; exactly 4 transfers; in_ready rises the cycle after the last transfer.
- Assert rst for 1 cycle during SORT (cycle 2) → next cycle state LOAD, busy=0, out_valid never rises. Reload 2,8,4,6 → output 8,6,4,2.

Source files
------------

// File: rtl/cas_sort_pkg.sv
// Shared types and helpers for the serial compare-and-swap sorter.
// Holds the controller state encoding and the per-phase pair count.
package cas_sort_pkg;

    localparam int SNG_WIDTH_DEFAULT = 10;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        SORT  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Even phases pair (0,1),(2,3)...; odd phases pair (1,2),(3,4)...
    function automatic int pairs_in_phase(input int n, input logic parity);
        return parity ? (n - 1) / 2 : n / 2;
    endfunction

endpackage

// File: rtl/cas.sv
// Combinational compare-and-swap: larger word to a_new, smaller to b_new.
// Zero latency; equal operands pass through unswapped.
module cas #(
    parameter int W = 10
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] a_new,
    output logic [W-1:0] b_new,
    output logic         swap
);

    assign swap  = (b > a);
    assign a_new = swap ? b : a;
    assign b_new = swap ? a : b;

endmodule

// File: rtl/cas_sort_ctrl.sv
// Loads N words, odd-even transposition sorts them one compare per cycle, drains descending.
// Sort takes at most N phases; loading and draining stall on in_valid / out_ready.
module cas_sort_ctrl
    import cas_sort_pkg::*;
#(
    parameter int SNG_WIDTH = SNG_WIDTH_DEFAULT,
    parameter int N         = 8,
    parameter int IDX_W     = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [SNG_WIDTH-1:0] in_data,
    output logic                 in_ready,
    output logic                 out_valid,
    output logic [SNG_WIDTH-1:0] out_data,
    input  logic                 out_ready,
    output logic                 out_last,
    output logic                 busy
);

    localparam logic [IDX_W-1:0] LAST_WORD      = IDX_W'(N - 1);
    localparam logic [IDX_W-1:0] LAST_PHASE     = IDX_W'(N - 1);
    localparam logic [IDX_W-1:0] LAST_PAIR_EVEN = IDX_W'(pairs_in_phase(N, 1'b0) - 1);
    localparam logic [IDX_W-1:0] LAST_PAIR_ODD  = IDX_W'(pairs_in_phase(N, 1'b1) - 1);

    state_t               state_q, state_d;
    logic [SNG_WIDTH-1:0] mem_q [N];
    logic [IDX_W-1:0]     wr_idx_q, wr_idx_d;
    logic [IDX_W-1:0]     rd_idx_q, rd_idx_d;
    logic [IDX_W-1:0]     pair_idx_q, pair_idx_d;
    logic [IDX_W-1:0]     phase_q, phase_d;
    logic                 swap_seen_q, swap_seen_d;
    logic [1:0]           quiet_q, quiet_d;

    logic [IDX_W-1:0]     lo_idx, hi_idx;
    logic [SNG_WIDTH-1:0] a_new, b_new;
    logic                 swap;
    logic                 last_pair;
    logic [1:0]           quiet_next;
    logic                 in_fire, out_fire;

    assign in_ready  = (state_q == LOAD)  && !rst;
    assign out_valid = (state_q == DRAIN) && !rst;
    assign busy      = (state_q == SORT)  && !rst;
    assign out_data  = rst ? '0 : mem_q[rd_idx_q];
    assign out_last  = out_valid && (rd_idx_q == LAST_WORD);

    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    // Pair base is 2*pair_idx, shifted by one on odd phases.
    assign lo_idx = IDX_W'({pair_idx_q, 1'b0}) | IDX_W'(phase_q[0]);
    assign hi_idx = lo_idx + IDX_W'(1);

    cas #(.W(SNG_WIDTH)) u_cas (
        .a     (mem_q[lo_idx]),
        .b     (mem_q[hi_idx]),
        .a_new (a_new),
        .b_new (b_new),
        .swap  (swap)
    );

    assign last_pair  = (pair_idx_q == (phase_q[0] ? LAST_PAIR_ODD : LAST_PAIR_EVEN));
    assign quiet_next = (swap_seen_q || swap) ? 2'd0 : quiet_q + 2'd1;

    always_comb begin
        state_d     = state_q;
        wr_idx_d    = wr_idx_q;
        rd_idx_d    = rd_idx_q;
        pair_idx_d  = pair_idx_q;
        phase_d     = phase_q;
        swap_seen_d = swap_seen_q;
        quiet_d     = quiet_q;
        case (state_q)
            LOAD: begin
                if (in_fire) begin
                    wr_idx_d = wr_idx_q + IDX_W'(1);
                    if (wr_idx_q == LAST_WORD) begin
                        wr_idx_d    = '0;
                        state_d     = SORT;
                        phase_d     = '0;
                        pair_idx_d  = '0;
                        swap_seen_d = 1'b0;
                        quiet_d     = 2'd0;
                    end
                end
            end
            SORT: begin
                swap_seen_d = swap_seen_q | swap;
                pair_idx_d  = pair_idx_q + IDX_W'(1);
                if (last_pair) begin
                    quiet_d     = quiet_next;
                    swap_seen_d = 1'b0;
                    pair_idx_d  = '0;
                    phase_d     = phase_q + IDX_W'(1);
                    // Two consecutive swap-free phases prove the bank is ordered.
                    if (quiet_next == 2'd2 || phase_q == LAST_PHASE) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (out_fire) begin
                    rd_idx_d = rd_idx_q + IDX_W'(1);
                    if (rd_idx_q == LAST_WORD) begin
                        rd_idx_d = '0;
                        state_d  = LOAD;
                    end
                end
            end
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= LOAD;
            wr_idx_q    <= '0;
            rd_idx_q    <= '0;
            pair_idx_q  <= '0;
            phase_q     <= '0;
            swap_seen_q <= 1'b0;
            quiet_q     <= 2'd0;
        end else begin
            state_q     <= state_d;
            wr_idx_q    <= wr_idx_d;
            rd_idx_q    <= rd_idx_d;
            pair_idx_q  <= pair_idx_d;
            phase_q     <= phase_d;
            swap_seen_q <= swap_seen_d;
            quiet_q     <= quiet_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (in_fire) begin
                mem_q[wr_idx_q] <= in_data;
            end
            if (state_q == SORT) begin
                mem_q[lo_idx] <= a_new;
                mem_q[hi_idx] <= b_new;
            end
        end
    end

endmodule
